icache_direct: RTL and testbench



---
 rtl/icache_direct.sv | 118 +++++++++++
 tb/tb_icache_direct.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache with a two-state fill FSM.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_direct #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t             state_q;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS];
    logic [31:0]        miss_addr_q;
    logic               iren_q;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               lookup_hit;
    logic               hit_d;
    logic               miss_d;
    logic               fill_d;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];

    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit_d  = (state_q == IDLE) && imemREN && !flush && lookup_hit;
    assign miss_d = (state_q == IDLE) && imemREN && !flush && !lookup_hit;
    // A flush in the completing cycle wins: the returned word is discarded.
    assign fill_d = (state_q == FETCH) && !iwait && !flush;

    assign ihit     = hit_d;
    assign imemload = hit_d ? data_q[req_idx] : 32'h0;
    assign iREN     = iren_q;
    assign iaddr    = miss_addr_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            iren_q      <= 1'b0;
            miss_addr_q <= 32'h0;
        end else if (flush) begin
            state_q <= IDLE;
            valid_q <= '0;
            iren_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_d) begin
                        miss_addr_q <= imemaddr & 32'hFFFF_FFFC;
                        state_q     <= FETCH;
                        iren_q      <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        valid_q[fill_idx] <= 1'b1;
                        state_q           <= IDLE;
                        iren_q            <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    iren_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays carry no reset; valid_q alone decides whether a frame is usable.
    always_ff @(posedge CLK) begin
        if (fill_d) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (hit_d)  hit_count  <= hit_count + 32'd1;
            if (miss_d) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Randomized bench for icache_direct against an address-keyed frame model and a scripted memory.
// Counter checks are active when ICACHE_STATS_EN is defined.
module tb_icache_direct;
    localparam int SETS  = 16;
    localparam int IDX_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    // Model: each frame remembers which word address it holds and that word's value.
    bit          m_valid [SETS];
    logic [31:0] m_addr  [SETS];
    logic [31:0] m_data  [SETS];
    logic [31:0] mem_ov  [logic [31:0]];

    always #5 clk = ~clk;

    icache_direct #(.SETS(SETS), .IDX_W(IDX_W)) dut (
        .CLK(clk), .RST(rst), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ov.exists(a)) return mem_ov[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
        chk({tag, "/hit_count"}, hit_count, exp_hits);
        chk({tag, "/miss_count"}, miss_count, exp_misses);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0; iwait = 1'b1; iload = 32'h0;
        #1;
        chk("reset/ihit", ihit, 0);
        chk("reset/imemload", imemload, 0);
        chk("reset/iREN", iREN, 0);
        chk("reset/iaddr", iaddr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        exp_hits = 0; exp_misses = 0;
        check_stats("reset");
    endtask

    // One fetch request; on a miss, serve it with 'waits' busy cycles.
    task automatic fetch(input logic [31:0] addr, input int waits, input bit drop_mid,
                         input bit flush_at_fill, input string tag);
        logic [31:0] wa;
        int i;
        bit exp_hit;
        wa = addr & 32'hFFFF_FFFC;
        i = idx_of(wa);
        exp_hit = m_valid[i] && (m_addr[i] == wa);
        imemREN = 1'b1; imemaddr = addr; flush = 1'b0; iwait = 1'b1; iload = $urandom;
        #1;
        chk({tag, "/ihit"}, ihit, exp_hit);
        chk({tag, "/idle_iREN"}, iREN, 0);
        if (exp_hit) begin
            chk({tag, "/imemload"}, imemload, m_data[i]);
            exp_hits++;
            @(posedge clk); #1;
            return;
        end
        chk({tag, "/miss_load"}, imemload, 0);
        exp_misses++;
        @(posedge clk); #1;
        for (int c = 0; c <= waits; c++) begin
            if (drop_mid) begin
                imemREN = 1'b0;
                imemaddr = $urandom;
            end
            iwait = (c < waits);
            iload = iwait ? $urandom : mem_word(wa);
            flush = flush_at_fill && (c == waits);
            #1;
            chk({tag, "/iREN"}, iREN, 1);
            chk({tag, "/iaddr"}, iaddr, wa);
            chk({tag, "/fetch_ihit"}, ihit, 0);
            @(posedge clk); #1;
        end
        flush = 1'b0; iwait = 1'b1; imemREN = 1'b0;
        if (flush_at_fill) begin
            model_clear();
        end else begin
            m_valid[i] = 1'b1; m_addr[i] = wa; m_data[i] = mem_word(wa);
        end
    endtask

    task automatic do_flush(input string tag);
        imemREN = 1'($urandom_range(0, 1)); imemaddr = $urandom_range(0, 255);
        flush = 1'b1;
        #1;
        chk({tag, "/ihit"}, ihit, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
    endtask

    initial begin
        int hits_before;
        logic [31:0] a;
        mem_ov[32'h0000_0040] = 32'h2002_0005;
        mem_ov[32'h0000_0000] = 32'hAAAA_0001;

        do_reset();
        fetch(32'h40, 2, 0, 0, "cold_miss");
        fetch(32'h40, 0, 0, 0, "repeat_hit");
        chk("repeat_hit/value", m_data[0], 32'h2002_0005);
        check_stats("after_cold");

        fetch(32'h0,  1, 0, 0, "conflict_fillA");
        fetch(32'h40, 1, 0, 0, "conflict_fillB");
        fetch(32'h0,  0, 0, 0, "conflict_reA");
        fetch(32'h0,  0, 0, 0, "conflict_hitA");

        do_reset();
        fetch(32'h4, 0, 0, 0, "flush_fill4");
        fetch(32'h8, 1, 0, 0, "flush_fill8");
        fetch(32'hC, 2, 0, 0, "flush_fillC");
        fetch(32'h8, 0, 0, 0, "flush_prehit");
        hits_before = exp_hits;
        do_flush("flush");
        fetch(32'h4, 0, 0, 0, "flush_re4");
        fetch(32'h8, 0, 0, 0, "flush_re8");
        fetch(32'hC, 0, 0, 0, "flush_reC");
`ifdef ICACHE_STATS_EN
        chk("flush/miss_count6", miss_count, 6);
        chk("flush/hit_unchanged", hit_count, hits_before);
`endif

        fetch(32'h100, 3, 1, 0, "drop_mid");
        fetch(32'h100, 0, 0, 0, "drop_mid_hit");

        fetch(32'h200, 2, 0, 1, "flush_fill");
        fetch(32'h200, 1, 0, 0, "flush_fill_remiss");
        check_stats("directed");

        // Asynchronous reset in the middle of a fetch drops iREN at once.
        imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid/iREN_before", iREN, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid/iREN_after", iREN, 0);
        chk("rst_mid/iaddr_after", iaddr, 0);
        @(posedge clk); #1;
        rst = 1'b0; imemREN = 1'b0;
        model_clear(); exp_hits = 0; exp_misses = 0;
        fetch(32'h300, 0, 0, 0, "rst_mid_remiss");

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 19);
            a = {($urandom_range(0, 3) == 0) ? 4'h1 : 4'h0, 20'h0, 6'($urandom_range(0, 47)), 2'($urandom_range(0, 3))};
            if (r == 0) begin
                do_flush("rnd_flush");
            end else if (r == 1) begin
                imemREN = 1'b0; imemaddr = a;
                #1;
                chk("rnd_idle/ihit", ihit, 0);
                @(posedge clk); #1;
            end else begin
                fetch(a, $urandom_range(0, 3), (r == 2), (r == 3), "rnd");
            end
        end
        check_stats("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule
